axis_fifo_param: RTL
====================

Name: axis_fifo_param

Overview:
- Parametrised synchronous AXI-Stream FIFO; next generation of the team's 8-bit/2048-entry stream buffer.
- Generalised data width and depth, with tlast stored per entry.
- Full AXI-Stream handshake on both sides, occupancy count and programmable almost-full/almost-empty flags.
- Sits between a stream producer (e.g. packet parser) and a consumer (e.g. DMA/serialiser) in the same clock domain.

Parameters:
- DATA_WIDTH, 8, bits per beat on s_tdata/m_tdata.
- DEPTH, 2048, number of entries; must be a power of two, >= 4.
- ALMOST_FULL_LVL, DEPTH-4, almost_full asserted when count >= this value.
- ALMOST_EMPTY_LVL, 4, almost_empty asserted when count <= this value.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- s_tdata  input  DATA_WIDTH  write-side data.
- s_tvalid  input  1  write-side valid.
- s_tready  output  1  write-side ready.
- s_tlast  input  1  write-side end-of-packet.
- m_tdata  output  DATA_WIDTH  read-side data.
- m_tvalid  output  1  read-side valid.
- m_tready  input  1  read-side ready.
- m_tlast  output  1  read-side end-of-packet.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= ALMOST_FULL_LVL.
- almost_empty  output  1  count <= ALMOST_EMPTY_LVL.

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+1) array; each entry holds {tlast, tdata}. No memory initialisation is required; contents after reset are don't-care.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits, and the extra MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (MSBs differ, lower bits equal).
  - Pointers wrap naturally from DEPTH-1 to 0 in the address field.
- Write acceptance: wr_fire = s_tvalid && s_tready. s_tready = !full, driven from registered state only and independent of s_tvalid and m_tready.
- Read acceptance: rd_fire = m_tvalid && m_tready.
- m_tdata/m_tlast: first-word-fall-through from mem[rd_ptr]. m_tvalid = !empty (see Optional Feature).
- Latency:
  - A beat written at edge N into an empty FIFO shows m_tvalid=1 in the cycle after edge N.
  - A read at edge N frees space, so s_tready=1 in the cycle after edge N.
- count is registered:
  - +1 on wr_fire only.
  - -1 on rd_fire only.
  - Unchanged when both fire or neither fires.
  - It must always equal wr_ptr - rd_ptr.
- Simultaneous events:
  - Full with m_tready=1: the read is accepted, the write is not (no pass-through), and s_tready rises in the next cycle.
  - Empty with s_tvalid=1: the write is accepted; there is no same-cycle bypass.
- While m_tvalid=1 and m_tready=0, m_tdata/m_tlast hold stable (AXI-Stream rule).
- Flags are combinational compares on the registered count, so they are glitch-free relative to clk.
- Reset (asynchronous assert, release synchronous to clk):
  - wr_ptr=rd_ptr=0, count=0.
  - s_tready=1, m_tvalid=0, almost_full=0, almost_empty=1.
  - A reset mid-packet discards all contents; partial packets are not recovered.
- No overflow or underflow is possible by construction. Beats presented while s_tready=0 are held by the producer per AXI-Stream.

Optional Feature:
- Macro: AXIS_FIFO_PKT_MODE_EN.
- Defined (store-and-forward):
  - Internal pkt_cnt ($clog2(DEPTH)+1 bits): +1 on wr_fire with s_tlast=1, -1 on rd_fire with m_tlast=1, unchanged when both occur.
  - m_tvalid = !empty && (pkt_cnt != 0 || full). The full term is a deadlock release for packets longer than DEPTH.
  - pkt_cnt resets to 0.
- Undefined: pkt_cnt is absent and m_tvalid = !empty (cut-through).
- Ports are identical in both builds.

Test Plan:
- Reset then idle -> s_tready=1, m_tvalid=0, count=0, almost_empty=1, almost_full=0.
- Write 0x01..0x05 (tlast on 0x05) with m_tready=0, then m_tready=1 -> m_tdata 0x01..0x05 in order, m_tlast=1 only on 0x05, count steps 5->0.
- Fill to DEPTH=16 with ALMOST_FULL_LVL=12 -> almost_full rises after beat 12, s_tready=0 after beat 16, count=16. Then hold s_tvalid=1 and m_tready=1 for one cycle -> exactly one read, no write, count=15, s_tready=1 in the next cycle.
- Continuous s_tvalid=m_tready=1 for 3*DEPTH beats with an incrementing pattern -> no lost or duplicated beat across pointer wrap, count constant at 1 in steady state.
- Assert reset_n=0 mid-packet with count=7 -> outputs return to reset values immediately, without waiting for a clock edge. After release, the first write of 0xAA is the first beat read.
- With AXIS_FIFO_PKT_MODE_EN: write 3 beats without tlast -> m_tvalid stays 0. Write a 4th beat with tlast -> m_tvalid=1 in the next cycle. A DEPTH-beat packet with no tlast -> m_tvalid=1 once full.

Source files
------------

// File: rtl/axis_fifo_param_if.sv
// rtl/axis_fifo_param_if.sv - write- and read-side AXI-Stream signals of axis_fifo_param
// slave is the FIFO's view; master is the producer/consumer environment's view.
interface axis_fifo_param_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_tdata;
  logic                  s_tvalid;
  logic                  s_tready;
  logic                  s_tlast;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/axis_fifo_param.sv
// rtl/axis_fifo_param.sv - parametrised AXI-Stream FIFO with per-entry tlast and level flags
// AXIS_FIFO_PKT_MODE_EN selects store-and-forward output gating instead of cut-through.
module axis_fifo_param #(
  parameter int DATA_WIDTH       = 8,
  parameter int DEPTH            = 2048,
  parameter int ALMOST_FULL_LVL  = DEPTH - 4,
  parameter int ALMOST_EMPTY_LVL = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  axis_fifo_param_if.slave         axis,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL_LVL);
  localparam logic [PW-1:0] AE_LVL = PW'(ALMOST_EMPTY_LVL);

  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          empty, full, wr_fire, rd_fire;

  // Extra pointer MSB is the wrap bit that tells full apart from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign axis.s_tready = !full;
  assign wr_fire = axis.s_tvalid && !full;
  assign rd_fire = axis.m_tvalid && axis.m_tready;

  assign {axis.m_tlast, axis.m_tdata} = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q[AW-1:0]] <= {axis.s_tlast, axis.s_tdata};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_fire);
    rd_ptr_d = rd_ptr_q + PW'(rd_fire);
    count_d  = count_q;
    if (wr_fire && !rd_fire) begin
      count_d = count_q + PW'(1);
    end else if (rd_fire && !wr_fire) begin
      count_d = count_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count        = count_q;
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);

`ifdef AXIS_FIFO_PKT_MODE_EN
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          pkt_in, pkt_out;

  assign pkt_in  = wr_fire && axis.s_tlast;
  assign pkt_out = rd_fire && axis.m_tlast;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_in && !pkt_out) begin
      pkt_cnt_d = pkt_cnt_q + PW'(1);
    end else if (pkt_out && !pkt_in) begin
      pkt_cnt_d = pkt_cnt_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // The full term releases packets longer than the buffer, which would otherwise deadlock.
  assign axis.m_tvalid = !empty && ((pkt_cnt_q != '0) || full);
`else
  assign axis.m_tvalid = !empty;
`endif

endmodule
